// File: rtl/keypad_emulator.sv
//----------------------------------------------------------------------------
// keypad_emulator
//
// Stands in for a 4x4 matrix push-button keypad in front of a column-scanning
// keypad reader. A key code is accepted through a valid/ready handshake. The
// emulator then "presses" that key for a fixed time, with optional contact
// chatter beforehand. It keeps the key released for a gap time and then
// signals completion.
//
// While pressed, the key's row line is pulled low only when the reader
// drives exactly that key's column. The row response is combinational from
// col, so the reader sees it in the same cycle it scans.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   key_code   in   4  key to press, 0x0..0xF
//   key_valid  in   1  key_code valid
//   key_ready  out  1  idle, will accept key_code
//   col        in   4  reader column drive, active-low one-hot
//   row        out  4  row lines to reader, active-low, 1111 = no key
//   busy       out  1  key sequence in progress
//   done       out  1  one-cycle pulse when a sequence completes
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_emulator #(
   parameter int HOLD_CYCLES   = 16,
   parameter int GAP_CYCLES    = 16,
   parameter int BOUNCE_CYCLES = 0,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BOUNCE = 2'd1,
      HOLD   = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Last counter value of each phase. The bounce value is unused when
   // BOUNCE_CYCLES is 0, so its truncated -1 never matters.
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       code_reg, code_next;
   logic             pressed_reg, pressed_next;
   logic             done_reg, done_next;

   logic [3:0]       col_pat;
   logic [3:0]       row_pat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         code_reg    <= 4'h0;
         pressed_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         code_reg    <= code_next;
         pressed_reg <= pressed_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CNT_W'(1);
      code_next  = code_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (key_valid) begin
               code_next  = key_code;
               state_next = (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
            end
         end
         BOUNCE: begin
            if (cnt_reg == BOUNCE_LAST) begin
               state_next = HOLD;
               cnt_next   = '0;
            end
         end
         HOLD: begin
            if (cnt_reg == HOLD_LAST) begin
               state_next = GAP;
               cnt_next   = '0;
            end
         end
         GAP: begin
            if (cnt_reg == GAP_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      // pressed is derived from the upcoming state and count. Registering it
      // keeps it aligned with the phase it belongs to, so the first pressed
      // cycle is the one right after the transfer edge. It also means pressed
      // cannot glitch while the counter changes.
      pressed_next = (state_next == HOLD) ||
                     ((state_next == BOUNCE) && !cnt_next[0]);
   end

   // The key's column sits at code[3:2] and its row at code[1:0].
   assign col_pat = ~(4'b0001 << code_reg[3:2]);
   assign row_pat = ~(4'b0001 << code_reg[1:0]);

   assign row       = (pressed_reg && (col == col_pat)) ? row_pat : 4'b1111;
   assign key_ready = (state_reg == IDLE);
   assign busy      = ~key_ready;
   assign done      = done_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
`timescale 1ns/1ps

module tb_keypad_emulator;

   // Instance 0: no bounce, short hold/gap. Instance 1: with chatter.
   localparam int B0 = 0, H0 = 4, G0 = 3;
   localparam int B1 = 4, H1 = 5, G1 = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [1:0][3:0] code_v;
   logic [1:0][3:0] col_v;
   logic [1:0][3:0] row_v;
   logic [1:0]      valid_v;
   logic [1:0]      ready_v;
   logic [1:0]      busy_v;
   logic [1:0]      done_v;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   keypad_emulator #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .BOUNCE_CYCLES(B0), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst_n), .key_code(code_v[0]), .key_valid(valid_v[0]),
      .key_ready(ready_v[0]), .col(col_v[0]), .row(row_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   keypad_emulator #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .BOUNCE_CYCLES(B1), .CNT_W(16)) dut_b (
      .clk(clk), .reset(rst_n), .key_code(code_v[1]), .key_valid(valid_v[1]),
      .key_ready(ready_v[1]), .col(col_v[1]), .row(row_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_cmp = n_cmp + 1;
      if (act_v !== exp_v) begin
         n_bad = n_bad + 1;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act_v, exp_v);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A sequence is described by the cycle it started (t0) and the offset
   // d = cycles since the transfer edge: d=1..B chatter, B+1..B+H held,
   // then G released cycles, then idle with done at d = B+H+G+1.
   int         cyc = 0;
   int         m_t0 [2];
   bit         m_act [2];
   logic [3:0] m_code [2];

   function automatic int len_b(int i); return (i == 0) ? B0 : B1; endfunction
   function automatic int len_h(int i); return (i == 0) ? H0 : H1; endfunction
   function automatic int len_g(int i); return (i == 0) ? G0 : G1; endfunction

   function automatic bit m_ready(int i);
      int d;
      d = cyc - m_t0[i];
      return !rst_n || !m_act[i] || (d >= len_b(i) + len_h(i) + len_g(i) + 1);
   endfunction

   function automatic bit m_pressed(int i);
      int d;
      d = cyc - m_t0[i];
      if (!rst_n || !m_act[i] || d < 1) return 1'b0;
      if (d <= len_b(i)) return ((d - 1) % 2) == 0;
      return d <= len_b(i) + len_h(i);
   endfunction

   function automatic bit m_done(int i);
      int d;
      d = cyc - m_t0[i];
      return rst_n && m_act[i] && (d == len_b(i) + len_h(i) + len_g(i) + 1);
   endfunction

   // Column index is code/4 and row index code%4. A col value is accepted
   // only if exactly that one line is low.
   function automatic logic [3:0] m_row(int i, logic [3:0] c);
      int ci, ri;
      logic [3:0] r;
      ci = int'(m_code[i]) / 4;
      ri = int'(m_code[i]) % 4;
      r = 4'b1111;
      if (m_pressed(i) && (int'(c ^ 4'b1111) == (1 << ci)))
         r[ri] = 1'b0;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) m_act[i] <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 2; i++) begin
            if (m_ready(i) && valid_v[i]) begin
               m_act[i]  <= 1'b1;
               m_t0[i]   <= cyc;
               m_code[i] <= code_v[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("row%0d", i),   row_v[i],   m_row(i, col_v[i]));
         chk($sformatf("ready%0d", i), ready_v[i], m_ready(i));
         chk($sformatf("busy%0d", i),  busy_v[i],  !m_ready(i));
         chk($sformatf("done%0d", i),  done_v[i],  m_done(i));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      while (!ready_v[i] && n < 100) begin
         step();
         n++;
      end
      chk($sformatf("wait_idle%0d", i), ready_v[i], 1);
   endtask

   logic [3:0] sw [6];
   logic [3:0] e5 [13];

   initial begin
      sw = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100};
      e5 = '{4'b0111, 4'b1111, 4'b0111, 4'b1111,
             4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111,
             4'b1111, 4'b1111, 4'b1111, 4'b1111};
      valid_v = 2'b00;
      code_v  = '0;
      col_v   = {4'hF, 4'hF};
      rst_n   = 1'b0;
      repeat (3) step();
      chk("rst_ready", ready_v[0], 1);
      chk("rst_busy",  busy_v[0],  0);
      chk("rst_done",  done_v[0],  0);
      chk("rst_row",   row_v[0],   4'b1111);
      rst_n = 1'b1;
      step();

      // Key 9, col fixed at its column: 4 pressed, 3 released, then done.
      code_v[0] = 4'h9; col_v[0] = 4'b1011; valid_v[0] = 1'b1;
      step();
      valid_v[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("t2_row",  row_v[0],  (k <= 4) ? 4'b1101 : 4'b1111);
         chk("t2_done", done_v[0], (k == 8) ? 1 : 0);
         if (k < 8) step();
      end
      step();

      // Key 9, column sweep during hold.
      code_v[0] = 4'h9; col_v[0] = 4'b1011; valid_v[0] = 1'b1;
      step();
      valid_v[0] = 1'b0;
      for (int j = 0; j < 6; j++) begin
         col_v[0] = sw[j];
         #1;
         chk("t3_row", row_v[0], (sw[j] == 4'b1011) ? 4'b1101 : 4'b1111);
         if (j % 2 == 1) step();
      end
      col_v[0] = 4'b1111;
      wait_idle(0);
      step();

      // Keys 0 then F with key_valid held high.
      code_v[0] = 4'h0; col_v[0] = 4'b1110; valid_v[0] = 1'b1;
      step();
      code_v[0] = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         if (k == 2) begin
            col_v[0] = 4'b0111;
            #1;
            chk("t4_othercol", row_v[0], 4'b1111);
            col_v[0] = 4'b1110;
            #1;
         end
         chk("t4_row0", row_v[0], (k <= 4) ? 4'b1110 : 4'b1111);
         if (k == 8) begin
            chk("t4_done",  done_v[0],  1);
            chk("t4_ready", ready_v[0], 1);
         end
         step();
      end
      valid_v[0] = 1'b0;
      col_v[0] = 4'b0111;
      #1;
      chk("t4_rowF", row_v[0],  4'b0111);
      chk("t4_busy", busy_v[0], 1);
      wait_idle(0);
      step();

      // Bounce 4 on the second instance, key 3.
      code_v[1] = 4'h3; col_v[1] = 4'b1110; valid_v[1] = 1'b1;
      step();
      valid_v[1] = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         chk("t5_row",  row_v[1],  e5[k-1]);
         chk("t5_done", done_v[1], (k == 13) ? 1 : 0);
         step();
      end

      // Reset in the middle of holding key 5.
      code_v[0] = 4'h5; col_v[0] = 4'b1101; valid_v[0] = 1'b1;
      step();
      valid_v[0] = 1'b0;
      step();
      chk("t1_row_pre", row_v[0], 4'b1101);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t1_row",   row_v[0],   4'b1111);
      chk("t1_ready", ready_v[0], 1);
      chk("t1_busy",  busy_v[0],  0);
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("t1_nodone", done_v[0], 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
